// File: rtl/dma_copy_master.sv
// Byte-enabled memory bus master that copies len bytes from src_addr to dst_addr,
// one bus access per cycle, using word transfers whenever both pointers are aligned.
module dma_copy_master #(
  parameter int unsigned MEM_BYTES = 16384,
  parameter logic [31:0] TAG_PC    = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] len,
  input  logic        irq_en,
  input  logic        irq_ack,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        irq,
  output logic [31:0] m_data_addr,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_inst_addr
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state, state_nxt;
  logic [31:0] src_q, dst_q, rd_buf;
  logic [15:0] rem_q, rem_dec;
  logic        irq_en_q, err_q, irq_q;
  logic        word_unit, range_bad;
  logic [32:0] src_end, dst_end;
  logic [31:0] step32;
  logic [7:0]  byte_sel;

  // rem still holds the latched len while in CHECK, so the range test uses it directly
  assign src_end   = {1'b0, src_q} + {17'd0, rem_q};
  assign dst_end   = {1'b0, dst_q} + {17'd0, rem_q};
  assign range_bad = (rem_q != 16'd0) &&
                     (src_end[32] || dst_end[32] || (src_end > MEM_LIMIT) || (dst_end > MEM_LIMIT));

  // src/dst/rem are stable across a READ/WRITE pair, so the unit choice is too
  assign word_unit = (src_q[1:0] == 2'b00) && (dst_q[1:0] == 2'b00) && (rem_q >= 16'd4);
  assign step32    = word_unit ? 32'd4 : 32'd1;
  assign rem_dec   = rem_q - (word_unit ? 16'd4 : 16'd1);
  assign byte_sel  = 8'(rd_buf >> {src_q[1:0], 3'b000});

  always_comb begin
    state_nxt     = state;
    m_data_addr   = 32'd0;
    m_data_wdata  = 32'd0;
    m_data_byteen = 4'd0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (range_bad || (rem_q == 16'd0)) state_nxt = S_DONE;
        else                               state_nxt = S_READ;
      end
      S_READ: begin
        m_data_addr = {src_q[31:2], 2'b00};
        state_nxt   = S_WRITE;
      end
      S_WRITE: begin
        m_data_addr = {dst_q[31:2], 2'b00};
        if (word_unit) begin
          m_data_wdata  = rd_buf;
          m_data_byteen = 4'b1111;
        end else begin
          m_data_wdata  = {4{byte_sel}};
          m_data_byteen = 4'b0001 << dst_q[1:0];
        end
        state_nxt = (rem_dec == 16'd0) ? S_DONE : S_READ;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // a reset sampled at the coming edge must not let the pending write commit
    if (!reset) m_data_byteen = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      src_q    <= 32'd0;
      dst_q    <= 32'd0;
      rem_q    <= 16'd0;
      rd_buf   <= 32'd0;
      irq_en_q <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q    <= src_addr;
            dst_q    <= dst_addr;
            rem_q    <= len;
            irq_en_q <= irq_en;
            err_q    <= 1'b0;
          end
        end
        S_CHECK: begin
          if (range_bad) err_q <= 1'b1;
        end
        S_READ: begin
          rd_buf <= m_data_rdata;
        end
        S_WRITE: begin
          src_q <= src_q + step32;
          dst_q <= dst_q + step32;
          rem_q <= rem_dec;
        end
        default: ;
      endcase
      // setting from DONE takes priority over a coincident acknowledge
      if ((state == S_DONE) && irq_en_q) irq_q <= 1'b1;
      else if (irq_ack)                  irq_q <= 1'b0;
    end
  end

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign err         = err_q;
  assign irq         = irq_q;
  assign m_inst_addr = TAG_PC;

endmodule
